maq_estados_mascota: RTL and testbench

Pet behaviour controller sitting above the four mode trackers (Ánimo, Energía, Descanso, Medicina). It reads their 2-bit levels and decides the pet's displayed state. It arbitrates the shared feed/medicate action: `Activo_Comida` and `Activo_Medicina` are never both high. It also implements test-mode stepping and a sticky death state driven by a 1 s tick prescaler.

---
 rtl/maq_estados_mascota_if.sv | 28 ++
 rtl/maq_estados_mascota.sv | 120 ++++++++++++
 tb/tb_maq_estados_mascota.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/maq_estados_mascota_if.sv
`default_nettype none
// maq_estados_mascota_if: level inputs, test controls and state/action outputs of the pet controller.
// Rev 1.0
interface maq_estados_mascota_if;
  logic [1:0] Nivel_Animo;
  logic [1:0] Nivel_Energia;
  logic [1:0] Nivel_Descanso;
  logic [1:0] Nivel_Medicina;
  logic       Senal_MTest;
  logic       Senal_Test;
  logic [2:0] estado;
  logic       Activo_Comida;
  logic       Activo_Medicina;
  logic       tick_1s;

  modport master (
    output Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina,
    output Senal_MTest, Senal_Test,
    input  estado, Activo_Comida, Activo_Medicina, tick_1s
  );

  modport slave (
    input  Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina,
    input  Senal_MTest, Senal_Test,
    output estado, Activo_Comida, Activo_Medicina, tick_1s
  );
endinterface
`default_nettype wire

// File: rtl/maq_estados_mascota.sv
`default_nettype none
// maq_estados_mascota: pet state controller with test stepping; MASCOTA_MUERTE_EN adds the sticky death state.
// Rev 1.0
module maq_estados_mascota #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int DEATH_TICKS = 10
) (
  input  wire logic             clk,
  input  wire logic             reset,
  maq_estados_mascota_if.slave  bus
);

  typedef enum logic [2:0] {
    NEUTRAL = 3'd0,
    FELIZ   = 3'd1,
    HAMBRE  = 3'd2,
    CANSADO = 3'd3,
    TRISTE  = 3'd4,
    ENFERMO = 3'd5,
    MUERTO  = 3'd6
  } estado_t;

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  estado_t       estado_q, estado_d, cand, step_nxt;
  logic          comida_q, comida_d, medicina_q, medicina_d;
  logic          mtest_q, mtest_d;
  logic          dead, death_hit;

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_comb begin
    if (bus.Nivel_Medicina == 2'd0)      cand = ENFERMO;
    else if (bus.Nivel_Energia == 2'd0)  cand = HAMBRE;
    else if (bus.Nivel_Descanso == 2'd0) cand = CANSADO;
    else if (bus.Nivel_Animo == 2'd0)    cand = TRISTE;
    else if (bus.Nivel_Animo[1] && bus.Nivel_Energia[1] &&
             bus.Nivel_Descanso[1] && bus.Nivel_Medicina[1]) cand = FELIZ;
    else                                 cand = NEUTRAL;
  end

`ifdef MASCOTA_MUERTE_EN
  localparam int            DW        = $clog2(DEATH_TICKS + 1);
  localparam logic [DW-1:0] DEATH_MAX = DW'(DEATH_TICKS);
  localparam estado_t       LAST      = MUERTO;

  logic [DW-1:0] death_q, death_d;
  logic [2:0]    n_crit;
  logic          multi_crit;

  // The counter saturating at DEATH_MAX doubles as the sticky death flag.
  // Death is still evaluated on the MTest rising cycle so it wins that race.
  always_comb begin
    n_crit     = {2'b0, bus.Nivel_Animo == 2'd0} + {2'b0, bus.Nivel_Energia == 2'd0} +
                 {2'b0, bus.Nivel_Descanso == 2'd0} + {2'b0, bus.Nivel_Medicina == 2'd0};
    multi_crit = (n_crit >= 3'd2);
    dead       = (death_q == DEATH_MAX);
    death_hit  = !dead && multi_crit && tick && (death_q == DEATH_MAX - 1'b1) &&
                 !(mtest_q && bus.Senal_MTest);
    death_d    = death_q;
    if (dead)                                death_d = death_q;
    else if (death_hit)                      death_d = DEATH_MAX;
    else if (bus.Senal_MTest || !multi_crit) death_d = '0;
    else if (tick)                           death_d = death_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) death_q <= '0;
    else        death_q <= death_d;
  end
`else
  localparam estado_t LAST = ENFERMO;

  assign dead      = 1'b0;
  assign death_hit = 1'b0;
`endif

  always_comb begin
    step_nxt = (estado_q >= LAST) ? NEUTRAL : estado_t'(estado_q + 3'd1);
    mtest_d  = bus.Senal_MTest;
    estado_d = estado_q;
    // A pulse arriving with the MTest rising edge is dropped: mode switches first.
    if (dead || death_hit)  estado_d = MUERTO;
    else if (bus.Senal_MTest) begin
      if (mtest_q && bus.Senal_Test) estado_d = step_nxt;
    end
    else                    estado_d = cand;
    comida_d   = (estado_d == NEUTRAL) || (estado_d == HAMBRE) || (estado_d == TRISTE);
    medicina_d = (estado_d == ENFERMO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q    <= '0;
      estado_q   <= NEUTRAL;
      comida_q   <= 1'b0;
      medicina_q <= 1'b0;
      mtest_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      estado_q   <= estado_d;
      comida_q   <= comida_d;
      medicina_q <= medicina_d;
      mtest_q    <= mtest_d;
    end
  end

  assign bus.estado          = estado_q;
  assign bus.Activo_Comida   = comida_q;
  assign bus.Activo_Medicina = medicina_q;
  assign bus.tick_1s         = tick;

endmodule
`default_nettype wire

// File: tb/tb_maq_estados_mascota.sv
`default_nettype none
// tb_maq_estados_mascota: directed self-checking bench (TICK_DIV=4, DEATH_TICKS=3); follows MASCOTA_MUERTE_EN.
// Rev 1.0
module tb_maq_estados_mascota;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef MASCOTA_MUERTE_EN
  localparam int LAST = 6;
`else
  localparam int LAST = 5;
`endif

  maq_estados_mascota_if mif ();

  maq_estados_mascota #(.TICK_DIV(4), .DEATH_TICKS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; invariants are checked on every cycle.
  task automatic step();
    @(posedge clk);
    #1;
    check("act_overlap", 32'(mif.Activo_Comida & mif.Activo_Medicina), 0);
    check("estado_7", 32'(mif.estado == 3'd7), 0);
  endtask

  task automatic set_lv(input logic [1:0] a, input logic [1:0] e, input logic [1:0] d, input logic [1:0] m);
    mif.Nivel_Animo    = a;
    mif.Nivel_Energia  = e;
    mif.Nivel_Descanso = d;
    mif.Nivel_Medicina = m;
  endtask

  task automatic apply(input logic [1:0] a, input logic [1:0] e, input logic [1:0] d, input logic [1:0] m,
                       input int st, input int c, input int md);
    set_lv(a, e, d, m);
    step();
    check("prio_estado", 32'(mif.estado), st);
    check("prio_comida", 32'(mif.Activo_Comida), c);
    check("prio_medicina", 32'(mif.Activo_Medicina), md);
  endtask

  // Advance until tick_1s is high for the current cycle (bounded).
  task automatic wait_tick();
    int n = 0;
    while (!mif.tick_1s && n < 8) begin
      step();
      n++;
    end
    check("tick_wait", 32'(mif.tick_1s), 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    int exp;
    reset = 1'b0;
    set_lv(2'd3, 2'd3, 2'd3, 2'd3);
    mif.Senal_MTest = 1'b0;
    mif.Senal_Test  = 1'b0;

    repeat (2) begin
      step();
      check("rst_estado", 32'(mif.estado), 0);
      check("rst_comida", 32'(mif.Activo_Comida), 0);
      check("rst_medicina", 32'(mif.Activo_Medicina), 0);
      check("rst_tick", 32'(mif.tick_1s), 0);
    end
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("rel_estado", 32'(mif.estado), 1);
      check("rel_act", 32'({mif.Activo_Comida, mif.Activo_Medicina}), 0);
      check("tick_period", 32'(mif.tick_1s), 32'((k % 4) == 3));
    end

    apply(2'd3, 2'd0, 2'd3, 2'd0, 5, 0, 1);
    apply(2'd3, 2'd0, 2'd3, 2'd3, 2, 1, 0);
    apply(2'd3, 2'd3, 2'd0, 2'd3, 3, 0, 0);
    apply(2'd0, 2'd3, 2'd3, 2'd3, 4, 1, 0);
    apply(2'd2, 2'd2, 2'd2, 2'd2, 1, 0, 0);
    apply(2'd1, 2'd3, 2'd3, 2'd3, 0, 1, 0);
    apply(2'd0, 2'd1, 2'd0, 2'd1, 3, 0, 0);
    apply(2'd3, 2'd3, 2'd3, 2'd3, 1, 0, 0);

`ifdef MASCOTA_MUERTE_EN
    wait_tick();
    step();
    set_lv(2'd3, 2'd0, 2'd0, 2'd3);
    step();
    check("death_start", 32'(mif.estado), 2);
    for (int n = 1; n <= 3; n++) begin
      wait_tick();
      check("death_pre", 32'(mif.estado), 2);
      step();
      check("death_count", 32'(mif.estado), (n == 3) ? 6 : 2);
    end
    check("dead_act", 32'({mif.Activo_Comida, mif.Activo_Medicina}), 0);
    set_lv(2'd3, 2'd3, 2'd3, 2'd3);
    repeat (5) begin
      step();
      check("dead_sticky", 32'(mif.estado), 6);
    end
    mif.Senal_MTest = 1'b1;
    step();
    mif.Senal_Test = 1'b1;
    step();
    mif.Senal_Test = 1'b0;
    step();
    check("dead_ignore_test", 32'(mif.estado), 6);
    mif.Senal_MTest = 1'b0;
    reset = 1'b0;
    #1;
    check("async_rst_estado", 32'(mif.estado), 0);
    check("async_rst_act", 32'({mif.Activo_Comida, mif.Activo_Medicina}), 0);
    check("async_rst_tick", 32'(mif.tick_1s), 0);
    step();
    check("rst_hold", 32'(mif.estado), 0);
    reset = 1'b1;
    step();
    check("after_death_rst", 32'(mif.estado), 1);

    wait_tick();
    step();
    set_lv(2'd3, 2'd0, 2'd0, 2'd3);
    wait_tick();
    step();
    wait_tick();
    step();
    check("clr_two_ticks", 32'(mif.estado), 2);
    set_lv(2'd3, 2'd0, 2'd3, 2'd3);
    step();
    check("clr_one", 32'(mif.estado), 2);
    set_lv(2'd3, 2'd0, 2'd0, 2'd3);
    step();
    for (int n = 1; n <= 3; n++) begin
      wait_tick();
      step();
      check("clr_recount", 32'(mif.estado), (n == 3) ? 6 : 2);
    end
`else
    set_lv(2'd3, 2'd0, 2'd0, 2'd3);
    repeat (40) begin
      step();
      check("nodeath_hold", 32'(mif.estado), 2);
    end
`endif

    do_reset();
    set_lv(2'd1, 2'd3, 2'd3, 2'd3);
    step();
    check("tm_pre", 32'(mif.estado), 0);
    mif.Senal_MTest = 1'b1;
    mif.Senal_Test  = 1'b1;
    step();
    mif.Senal_Test = 1'b0;
    check("tm_rise_pulse", 32'(mif.estado), 0);
    check("tm_rise_comida", 32'(mif.Activo_Comida), 1);
    set_lv(2'd3, 2'd0, 2'd3, 2'd0);
    step();
    check("tm_levels_ignored", 32'(mif.estado), 0);
    exp = 0;
    for (int p = 0; p < 7; p++) begin
      mif.Senal_Test = 1'b1;
      step();
      mif.Senal_Test = 1'b0;
      exp = (exp == LAST) ? 0 : exp + 1;
      check("tm_step", 32'(mif.estado), exp);
      check("tm_comida", 32'(mif.Activo_Comida), 32'(exp == 0 || exp == 2 || exp == 4));
      check("tm_medicina", 32'(mif.Activo_Medicina), 32'(exp == 5));
      step();
      step();
      check("tm_hold", 32'(mif.estado), exp);
    end
    set_lv(2'd3, 2'd3, 2'd3, 2'd3);
    mif.Senal_MTest = 1'b0;
    step();
    check("tm_exit", 32'(mif.estado), 1);
    check("tm_exit_act", 32'({mif.Activo_Comida, mif.Activo_Medicina}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
